// File: rtl/proj_to_affine_if.sv
// Handshake and data bundle for proj_to_affine.
// o_error is present only when PROJ_TO_AFFINE_ZERO_CHECK_EN is defined.
interface proj_to_affine_if;
  logic         i_start;
  logic [254:0] i_x;
  logic [254:0] i_y;
  logic [254:0] i_z;
  logic [254:0] o_x;
  logic [254:0] o_y;
  logic         o_finished;
  logic         o_busy;
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
  logic         o_error;

  modport master (output i_start, i_x, i_y, i_z,
                  input  o_x, o_y, o_finished, o_busy, o_error);
  modport slave  (input  i_start, i_x, i_y, i_z,
                  output o_x, o_y, o_finished, o_busy, o_error);
`else
  modport master (output i_start, i_x, i_y, i_z,
                  input  o_x, o_y, o_finished, o_busy);
  modport slave  (input  i_start, i_x, i_y, i_z,
                  output o_x, o_y, o_finished, o_busy);
`endif
endinterface

// File: rtl/proj_to_affine.sv
// Projective (x,y,z) to affine (x/z, y/z) over GF(2^255-19) via Fermat inversion.
// Build option PROJ_TO_AFFINE_ZERO_CHECK_EN adds o_error and a short path for z == 0.
//
// state   | meaning
// S_IDLE  | waiting for i_start
// S_LOAD  | operands latched, acc = z, bit index = 253
// S_SQR   | acc = acc*acc (256 cycles)
// S_MUL   | acc = acc*z   (256 cycles, exponent bit set)
// S_MUL_X | x = x*inv     (256 cycles)
// S_MUL_Y | y = y*inv     (256 cycles)
// S_DONE  | publish o_x/o_y, pulse o_finished
`ifndef N
`define N 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
`endif

module proj_to_affine (
  input  logic            i_clk,
  input  logic            i_rst_n,
  proj_to_affine_if.slave bus
);
  localparam logic [254:0] P   = `N;
  localparam logic [254:0] EXP = P - 255'd2;
  localparam logic [256:0] P_W = {2'b00, P};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SQR, S_MUL, S_MUL_X, S_MUL_Y, S_DONE
  } state_t;

  state_t       state, state_d;
  logic [254:0] x_q, y_q, z_q, ex_acc;
  logic [7:0]   bit_idx;
  logic [7:0]   cnt;
  logic [254:0] m_a, m_b, m_acc;
  logic [254:0] op_a, mul_res;
  logic [256:0] t0, t1;
  logic [254:0] o_x_q, o_y_q;
  logic         fin_q, busy_q;
  logic         in_op, op_last, exp_bit, zero_z;
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
  logic         zero_q, err_q;
  assign bus.o_error = err_q;
`endif

  assign in_op   = state inside {S_SQR, S_MUL, S_MUL_X, S_MUL_Y};
  assign op_last = in_op && (cnt == 8'd255);
  assign exp_bit = EXP[bit_idx];
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
  assign zero_z  = (z_q == 255'd0);
`else
  assign zero_z  = 1'b0;
`endif

  // One MSB-first step: acc = 2*acc + b_i*a, result < 3p so two subtractions suffice.
  assign t0      = {1'b0, m_acc, 1'b0} + (m_b[254] ? {2'b00, m_a} : 257'd0);
  assign t1      = (t0 >= P_W) ? (t0 - P_W) : t0;
  assign mul_res = (t1 >= P_W) ? 255'(t1 - P_W) : t1[254:0];

  always_comb begin
    op_a = ex_acc;
    case (state)
      S_MUL:   op_a = z_q;
      S_MUL_X: op_a = x_q;
      S_MUL_Y: op_a = y_q;
      default: op_a = ex_acc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (bus.i_start) state_d = S_LOAD;
      S_LOAD:  state_d = zero_z ? S_DONE : S_SQR;
      S_SQR:   if (op_last) begin
                 if (exp_bit)              state_d = S_MUL;
                 else if (bit_idx == 8'd0) state_d = S_MUL_X;
               end
      S_MUL:   if (op_last) state_d = (bit_idx == 8'd0) ? S_MUL_X : S_SQR;
      S_MUL_X: if (op_last) state_d = S_MUL_Y;
      S_MUL_Y: if (op_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      ex_acc  <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      m_a     <= '0;
      m_b     <= '0;
      m_acc   <= '0;
      o_x_q   <= '0;
      o_y_q   <= 255'd1;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      fin_q  <= (state == S_DONE);
      busy_q <= (state_d != S_IDLE) || (state == S_DONE);

      if (state == S_IDLE && bus.i_start) begin
        x_q     <= bus.i_x;
        y_q     <= bus.i_y;
        z_q     <= bus.i_z;
        ex_acc  <= bus.i_z;
        bit_idx <= 8'd253;
      end

`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
      if (state == S_LOAD) begin
        zero_q <= zero_z;
        if (zero_z) begin
          x_q <= '0;
          y_q <= '0;
        end
      end
`endif

      if (in_op) begin
        cnt <= cnt + 8'd1;
        if (cnt == 8'd0) begin
          m_a   <= op_a;
          m_b   <= ex_acc;
          m_acc <= '0;
        end else begin
          m_acc <= mul_res;
          m_b   <= {m_b[253:0], 1'b0};
        end
      end

      if (op_last) begin
        if (state == S_SQR || state == S_MUL) ex_acc <= mul_res;
        if (state == S_MUL_X)                 x_q    <= mul_res;
        if (state == S_MUL_Y)                 y_q    <= mul_res;
        if (((state == S_SQR && !exp_bit) || state == S_MUL) && bit_idx != 8'd0)
          bit_idx <= bit_idx - 8'd1;
      end

      if (state == S_DONE) begin
        o_x_q <= x_q;
        o_y_q <= y_q;
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
        err_q <= zero_q;
`endif
      end
    end
  end

  assign bus.o_x        = o_x_q;
  assign bus.o_y        = o_y_q;
  assign bus.o_finished = fin_q;
  assign bus.o_busy     = busy_q;
endmodule

// File: tb/tb_proj_to_affine.sv
// Self-checking bench for proj_to_affine: vector table, randomized points, abort and restart sequences.
`ifndef N
`define N 255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed
`endif

module tb_proj_to_affine;
  localparam logic [254:0] P     = `N;
  localparam int           LAT   = 130050;
  localparam int           LIMIT = 131000;
  localparam logic [254:0] GX = 255'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
  localparam logic [254:0] GY = 255'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;

  typedef struct {
    logic [254:0] x, y, z;
    logic [254:0] ex, ey;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fin_count = 0;

  proj_to_affine_if bus();
  proj_to_affine dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #1 clk = ~clk;
  always @(negedge clk) if (bus.o_finished) fin_count++;

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [509:0] pr;
    pr = 510'(a) * 510'(b);
    pr = pr % 510'(P);
    return pr[254:0];
  endfunction

  function automatic logic [254:0] rand_fe();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    r[255] = 1'b0;
    if (r[254:0] >= P) r = r - {1'b0, P};
    return r[254:0];
  endfunction

  // Affine point (ax, ay) scaled by z: the bench knows the answer before the DUT runs.
  function automatic vec_t make_vec(input logic [254:0] ax, input logic [254:0] ay, input logic [254:0] z);
    vec_t v;
    v.x = mulmod(ax, z); v.y = mulmod(ay, z); v.z = z;
    v.ex = ax; v.ey = ay; v.lat = LAT;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [254:0] act, input logic [254:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, id, act, exp);
    end
  endtask

  task automatic run_op(input int id, input vec_t v, input int inject_at);
    int   lat, f0;
    logic busy1, busy_fin;
    f0 = fin_count;
    busy1 = 1'b0;
    @(negedge clk);
    bus.i_x = v.x; bus.i_y = v.y; bus.i_z = v.z; bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_x = rand_fe(); bus.i_y = rand_fe(); bus.i_z = rand_fe();
    lat = 0;
    while (lat < LIMIT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) busy1 = bus.o_busy;
      bus.i_start = (lat == inject_at);
      if (lat == inject_at) begin
        bus.i_x = rand_fe(); bus.i_y = rand_fe(); bus.i_z = rand_fe();
      end
      if (bus.o_finished) break;
    end
    bus.i_start = 1'b0;
    chk("latency", id, 255'(lat), 255'(v.lat));
    chk("o_x", id, bus.o_x, v.ex);
    chk("o_y", id, bus.o_y, v.ey);
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
    chk("o_error", id, 255'(bus.o_error), 255'(v.z == 255'd0));
`endif
    busy_fin = bus.o_busy;
    chk("busy_after_accept", id, 255'(busy1), 255'd1);
    chk("busy_at_finish", id, 255'(busy_fin), 255'd1);
    repeat (3) @(negedge clk);
    chk("busy_idle", id, 255'(bus.o_busy), 255'd0);
    chk("o_x_hold", id, bus.o_x, v.ex);
    @(posedge clk);
    chk("finished_pulses", id, 255'(fin_count - f0), 255'd1);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t rv;
    int   f0;

    vecs[0] = '{x: 255'd9, y: 255'd5, z: 255'd1, ex: 255'd9, ey: 255'd5, lat: LAT};
    vecs[1] = '{x: 255'd2, y: 255'd4, z: 255'd2, ex: 255'd1, ey: 255'd2, lat: LAT};
    vecs[2] = '{x: 255'd1, y: 255'd1, z: P - 255'd1, ex: P - 255'd1, ey: P - 255'd1, lat: LAT};
    vecs[3] = make_vec(GX, GY, 255'd12345);
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
    vecs[4] = '{x: 255'd7, y: 255'd3, z: 255'd0, ex: 255'd0, ey: 255'd0, lat: 2};
`else
    vecs[4] = '{x: 255'd7, y: 255'd3, z: 255'd0, ex: 255'd0, ey: 255'd0, lat: LAT};
`endif

    bus.i_start = 1'b0; bus.i_x = '0; bus.i_y = '0; bus.i_z = '0;
    repeat (3) @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    chk("rst_o_x", 0, bus.o_x, 255'd0);
    chk("rst_o_y", 0, bus.o_y, 255'd1);
    chk("rst_finished", 0, 255'(bus.o_finished), 255'd0);
    chk("rst_busy", 0, 255'(bus.o_busy), 255'd0);
`ifdef PROJ_TO_AFFINE_ZERO_CHECK_EN
    chk("rst_error", 0, 255'(bus.o_error), 255'd0);
`endif
    bus.i_start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) run_op(i, vecs[i], -1);

    // Random point with a second request and new inputs 1000 cycles in.
    rv = make_vec(rand_fe(), rand_fe(), rand_fe() | 255'd1);
    run_op(10, rv, 1000);

    // Abort mid-operation, then a fresh full-length run.
    f0 = fin_count;
    @(negedge clk);
    bus.i_x = rand_fe(); bus.i_y = rand_fe(); bus.i_z = rand_fe() | 255'd1; bus.i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (59999) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #0.5;
    chk("abort_o_x", 20, bus.o_x, 255'd0);
    chk("abort_o_y", 20, bus.o_y, 255'd1);
    chk("abort_busy", 20, 255'(bus.o_busy), 255'd0);
    chk("abort_finished", 20, 255'(bus.o_finished), 255'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rv = make_vec(rand_fe(), rand_fe(), rand_fe() | 255'd1);
    run_op(21, rv, -1);
    chk("abort_total_pulses", 20, 255'(fin_count - f0), 255'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
